// File: rtl/conv_window_generator_pkg.sv
// conv_window_generator_pkg: shared defaults, window size and counter-width helpers
// Holds default geometry plus helpers that derive window size and counter widths.
package conv_window_generator_pkg;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_IMAGE_WIDTH = 28;
  localparam int DEF_IMAGE_HEIGHT = 28;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int WINDOW_PIXELS = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;
  function automatic int window_pixels(input int k);
    return k * k;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int COL_W = cnt_w(DEF_IMAGE_WIDTH);
  localparam int ROW_W = cnt_w(DEF_IMAGE_HEIGHT);
endpackage

// File: rtl/conv_window_generator_if.sv
// conv_window_generator_if: pixel stream in, flattened window stream out
// master (upstream/bench): drives data_valid, pixel_in_data; reads window_out, window_valid, frame_done.
// slave (generator): the reverse.
interface conv_window_generator_if
  import conv_window_generator_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) ();
  logic data_valid;
  logic [DATA_SIZE-1:0] pixel_in_data;
  logic [window_pixels(KERNEL_SIZE)*DATA_SIZE-1:0] window_out;
  logic window_valid;
  logic frame_done;
  modport master (
    output data_valid, pixel_in_data,
    input  window_out, window_valid, frame_done
  );
  modport slave (
    input  data_valid, pixel_in_data,
    output window_out, window_valid, frame_done
  );
endinterface

// File: rtl/conv_window_generator_line_buffer.sv
// line_buffer: enabled shift register delaying accepted pixels by DEPTH accepts
// Ports: clock, reset (async, active-high), shift_en, din in; dout = oldest entry (tap DEPTH-1).
module line_buffer #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH = 28
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);
  logic [DATA_SIZE-1:0] mem [DEPTH];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (shift_en) begin
      mem[0] <= din;
      for (int k = 1; k < DEPTH; k++) mem[k] <= mem[k-1];
    end
  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/conv_window_generator.sv
// conv_window_generator: KERNEL_SIZE x KERNEL_SIZE sliding window over a raster pixel stream
// Ports: clock, reset (async, active-high); bus (slave): data_valid/pixel_in_data in,
// window_out (index 0 = top-left oldest), window_valid, frame_done out, all registered.
module conv_window_generator
  import conv_window_generator_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input logic clock,
  input logic reset,
  conv_window_generator_if.slave bus
);
  localparam int CW = cnt_w(IMAGE_WIDTH);
  localparam int RW = cnt_w(IMAGE_HEIGHT);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic col_last, row_last, in_region;
  logic window_valid, frame_done;
  logic [DATA_SIZE-1:0] win [KERNEL_SIZE][KERNEL_SIZE];
  // row_in[i] is the pixel entering window row i: the live pixel for the bottom row,
  // and the same pixel delayed by one more image line for each row above.
  logic [DATA_SIZE-1:0] row_in [KERNEL_SIZE];
  assign row_in[KERNEL_SIZE-1] = bus.pixel_in_data;
  genvar i, j;
  for (i = 0; i < KERNEL_SIZE - 1; i++) begin : g_lb
    line_buffer #(.DATA_SIZE(DATA_SIZE), .DEPTH(IMAGE_WIDTH)) u_lb (
      .clock    (clock),
      .reset    (reset),
      .shift_en (bus.data_valid),
      .din      (row_in[i+1]),
      .dout     (row_in[i])
    );
  end
  for (i = 0; i < KERNEL_SIZE; i++) begin : g_row
    for (j = 0; j < KERNEL_SIZE; j++) begin : g_col
      assign bus.window_out[(i*KERNEL_SIZE+j)*DATA_SIZE +: DATA_SIZE] = win[i][j];
    end
  end
  assign col_last = col == CW'(IMAGE_WIDTH - 1);
  assign row_last = row == RW'(IMAGE_HEIGHT - 1);
  // Row/column gating also hides row-wrap windows and stale previous-frame data.
  assign in_region = int'(row) >= KERNEL_SIZE - 1 && int'(col) >= KERNEL_SIZE - 1;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE; c++) win[r][c] <= '0;
    end else if (bus.data_valid) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) win[r][c] <= win[r][c+1];
        win[r][KERNEL_SIZE-1] <= row_in[r];
      end
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      col <= '0;
      row <= '0;
      window_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      window_valid <= bus.data_valid && in_region;
      frame_done <= bus.data_valid && col_last && row_last;
      if (bus.data_valid) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
      end
    end
  assign bus.window_valid = window_valid;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_conv_window_generator.sv
// tb_conv_window_generator: directed checks on a 4x4 instance and a 28x28 random-image instance
module tb_conv_window_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int nv, nf;
  logic [7:0] img [28][28];
  always #5 clk = ~clk;
  conv_window_generator_if #(.DATA_SIZE(8), .KERNEL_SIZE(3)) bs ();
  conv_window_generator_if #(.DATA_SIZE(8), .KERNEL_SIZE(3)) bl ();
  conv_window_generator #(.DATA_SIZE(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3)) dut_s (
    .clock (clk),
    .reset (rst),
    .bus   (bs)
  );
  conv_window_generator #(.DATA_SIZE(8), .IMAGE_WIDTH(28), .IMAGE_HEIGHT(28), .KERNEL_SIZE(3)) dut_l (
    .clock (clk),
    .reset (rst),
    .bus   (bl)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [71:0] win_exp(input int base, input int tl);
    int offs [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(base + tl + offs[k]);
    return w;
  endfunction
  task automatic send_s(input logic dv, input logic [7:0] pix);
    bs.data_valid = dv;
    bs.pixel_in_data = pix;
    @(posedge clk);
    #1;
  endtask
  task automatic frame_s(input int base, input bit gaps);
    logic vexp;
    for (int p = 0; p < 16; p++) begin
      if (gaps) begin
        send_s(1'b0, 8'hEE);
        chk("gap_valid", bs.window_valid, 0);
        chk("gap_done", bs.frame_done, 0);
      end
      send_s(1'b1, 8'(base + p));
      vexp = p == 10 || p == 11 || p == 14 || p == 15;
      chk($sformatf("valid_p%0d", p), bs.window_valid, vexp);
      chk($sformatf("done_p%0d", p), bs.frame_done, p == 15);
      if (vexp) chk($sformatf("window_p%0d", p), bs.window_out, win_exp(base, p - 10));
      nv += int'(bs.window_valid);
      nf += int'(bs.frame_done);
    end
    bs.data_valid = 1'b0;
  endtask
  initial begin
    bs.data_valid = 1'b0;
    bs.pixel_in_data = '0;
    bl.data_valid = 1'b0;
    bl.pixel_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_window", bs.window_out, 0);
    chk("rst_valid", bs.window_valid, 0);
    chk("rst_done", bs.frame_done, 0);
    rst = 1'b0;
    send_s(1'b0, 8'h00);
    nv = 0; nf = 0;
    frame_s(0, 1'b0);
    chk("gapless_windows", nv, 4);
    chk("gapless_done", nf, 1);
    send_s(1'b0, 8'h00);
    chk("idle_valid", bs.window_valid, 0);
    nv = 0; nf = 0;
    frame_s(0, 1'b1);
    chk("toggle_windows", nv, 4);
    chk("toggle_done", nf, 1);
    nv = 0; nf = 0;
    frame_s(0, 1'b0);
    frame_s(100, 1'b0);
    chk("b2b_windows", nv, 8);
    chk("b2b_done", nf, 2);
    for (int p = 0; p < 8; p++) send_s(1'b1, 8'(p + 1));
    chk("prereset_window", bs.window_out != 0, 1);
    bs.data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_window", bs.window_out, 0);
    chk("async_rst_valid", bs.window_valid, 0);
    chk("async_rst_done", bs.frame_done, 0);
    #2 rst = 1'b0;
    nv = 0; nf = 0;
    frame_s(0, 1'b0);
    chk("post_rst_windows", nv, 4);
    chk("post_rst_done", nf, 1);
    nv = 0; nf = 0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        logic [71:0] w;
        logic vexp;
        img[r][c] = 8'($urandom_range(0, 255));
        bl.data_valid = 1'b1;
        bl.pixel_in_data = img[r][c];
        @(posedge clk);
        #1;
        vexp = r >= 2 && c >= 2;
        chk($sformatf("big_valid_%0d_%0d", r, c), bl.window_valid, vexp);
        chk($sformatf("big_done_%0d_%0d", r, c), bl.frame_done, r == 27 && c == 27);
        if (vexp) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) w[(i*3+j)*8 +: 8] = img[r-2+i][c-2+j];
          chk($sformatf("big_window_%0d_%0d", r, c), bl.window_out, w);
        end
        nv += int'(bl.window_valid);
        nf += int'(bl.frame_done);
      end
    bl.data_valid = 1'b0;
    chk("big_windows", nv, 676);
    chk("big_done", nf, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
